// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw button levels and repeat enables in,
// conditioned command pulses and debounced levels out.
interface button_conditioner_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] buttons;
    logic [WIDTH-1:0] repeat_en;
    logic [WIDTH-1:0] pulses;
    logic [WIDTH-1:0] held;

    modport master (
        output buttons,
        output repeat_en,
        input  pulses,
        input  held
    );

    modport slave (
        input  buttons,
        input  repeat_en,
        output pulses,
        output held
    );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner: per channel two-FF synchronizer, counter-based
// debounce and optional auto-repeat. It produces one clean pulse per press,
// plus repeat pulses while the button is held. Channels are independent.
module button_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                rst,
    button_conditioner_if.slave bus
);

    typedef enum logic {
        STABLE_LO = 1'b0,
        STABLE_HI = 1'b1
    } db_state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;
    logic [WIDTH-1:0] pulses_s;
    logic [WIDTH-1:0] held_s;

    // Two-stage synchronizer for the asynchronous raw button levels.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_r <= {WIDTH{1'b0}};
            s2_r <= {WIDTH{1'b0}};
        end else begin
            s1_r <= bus.buttons;
            s2_r <= s1_r;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        db_state_t        state_r;
        db_state_t        state_nx_s;
        logic [CNT_W-1:0] db_cnt_r;
        logic [CNT_W-1:0] db_cnt_nx_s;
        logic [CNT_W-1:0] rp_cnt_r;
        logic [CNT_W-1:0] rp_cnt_nx_s;
        logic [CNT_W-1:0] rp_last_s;
        logic             rp_sub_r;
        logic             rp_sub_nx_s;
        logic             press_s;
        logic             release_s;
        logic             repeat_s;
        logic             pulse_r;
        logic             held_r;

        // Debounce FSM: flip the stable state after DEBOUNCE_CYCLES of disagreement.
        always_comb begin
            state_nx_s  = state_r;
            db_cnt_nx_s = db_cnt_r;
            press_s     = 1'b0;
            release_s   = 1'b0;
            case (state_r)
                STABLE_LO: begin
                    if (s2_r[g]) begin
                        if (db_cnt_r == DB_LAST) begin
                            state_nx_s  = STABLE_HI;
                            db_cnt_nx_s = CNT_ZERO;
                            press_s     = 1'b1;
                        end else begin
                            db_cnt_nx_s = db_cnt_r + CNT_ONE;
                        end
                    end else begin
                        db_cnt_nx_s = CNT_ZERO;
                    end
                end
                STABLE_HI: begin
                    if (!s2_r[g]) begin
                        if (db_cnt_r == DB_LAST) begin
                            state_nx_s  = STABLE_LO;
                            db_cnt_nx_s = CNT_ZERO;
                            release_s   = 1'b1;
                        end else begin
                            db_cnt_nx_s = db_cnt_r + CNT_ONE;
                        end
                    end else begin
                        db_cnt_nx_s = CNT_ZERO;
                    end
                end
                default: begin
                    state_nx_s  = STABLE_LO;
                    db_cnt_nx_s = CNT_ZERO;
                end
            endcase
        end

        // Auto-repeat timer: first wait is REPEAT_DELAY, later ones REPEAT_PERIOD.
        always_comb begin
            rp_cnt_nx_s = rp_cnt_r;
            rp_sub_nx_s = rp_sub_r;
            repeat_s    = 1'b0;
            if (rp_sub_r) begin
                rp_last_s = PERIOD_LAST;
            end else begin
                rp_last_s = DELAY_LAST;
            end
            if ((state_r != STABLE_HI) || release_s) begin
                // Not held (or releasing now): any pending repeat is dropped.
                rp_cnt_nx_s = CNT_ZERO;
                rp_sub_nx_s = 1'b0;
            end else if (!bus.repeat_en[g]) begin
                // Disabled: re-enabling restarts the full first-repeat wait.
                rp_cnt_nx_s = CNT_ZERO;
                rp_sub_nx_s = 1'b0;
            end else if (rp_cnt_r == rp_last_s) begin
                rp_cnt_nx_s = CNT_ZERO;
                rp_sub_nx_s = 1'b1;
                repeat_s    = 1'b1;
            end else begin
                rp_cnt_nx_s = rp_cnt_r + CNT_ONE;
            end
        end

        // Channel state and registered outputs.
        always_ff @(posedge clk) begin
            if (!rst) begin
                state_r  <= STABLE_LO;
                db_cnt_r <= CNT_ZERO;
                rp_cnt_r <= CNT_ZERO;
                rp_sub_r <= 1'b0;
                pulse_r  <= 1'b0;
                held_r   <= 1'b0;
            end else begin
                state_r  <= state_nx_s;
                db_cnt_r <= db_cnt_nx_s;
                rp_cnt_r <= rp_cnt_nx_s;
                rp_sub_r <= rp_sub_nx_s;
                pulse_r  <= press_s | repeat_s;
                held_r   <= (state_nx_s == STABLE_HI);
            end
        end

        assign pulses_s[g] = pulse_r;
        assign held_s[g]   = held_r;
    end

    assign bus.pulses = pulses_s;
    assign bus.held   = held_s;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios followed by random
// stimulus, every cycle compared against a window/arithmetic reference model.
module tb_button_conditioner;

    localparam int WIDTH = 8;
    localparam int DB    = 4;
    localparam int RD    = 10;
    localparam int RP    = 3;
    localparam int CNT_W = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    button_conditioner_if #(.WIDTH(WIDTH)) bus ();

    button_conditioner #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .CNT_W           (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference model state.
    int               edge_n = 0;
    logic [WIDTH-1:0] hist [$];          // raw samples, newest at the back
    logic [WIDTH-1:0] stable_m = '0;
    logic [WIDTH-1:0] exp_pulses = '0;
    logic [WIDTH-1:0] exp_held = '0;
    int               anchor [WIDTH];

    // Observation counters used by directed checks.
    int pulse_cnt [WIDTH];
    int held_cnt  [WIDTH];

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs,
                            input logic [WIDTH-1:0] exp_v);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp_v, edge_n);
        end
    endtask

    // Model of one clock edge: the stable state flips once the last DB
    // synchronized samples (raw delayed by two edges) all disagree with it;
    // repeats fall at anchor + RD + n*RP while held and enabled.
    task automatic model_edge();
        logic [WIDTH-1:0] nstable;
        edge_n++;
        if (!rst) begin
            hist.delete();
            for (int j = 0; j < DB + 1; j++) hist.push_back('0);
            stable_m   = '0;
            exp_pulses = '0;
            exp_held   = '0;
        end else begin
            nstable = stable_m;
            for (int i = 0; i < WIDTH; i++) begin
                bit flip;
                bit press;
                bit rel;
                bit rep;
                int d;
                flip = 1'b1;
                for (int j = 1; j <= DB; j++)
                    if (hist[hist.size() - 1 - j][i] == stable_m[i]) flip = 1'b0;
                press = flip && !stable_m[i];
                rel   = flip && stable_m[i];
                d     = edge_n - anchor[i];
                rep   = stable_m[i] && bus.repeat_en[i] && !rel &&
                        (d >= RD) && (((d - RD) % RP) == 0);
                if (press) anchor[i] = edge_n;
                else if (stable_m[i] && !bus.repeat_en[i]) anchor[i] = edge_n;
                if (flip) nstable[i] = ~stable_m[i];
                exp_pulses[i] = press || rep;
            end
            stable_m = nstable;
            exp_held = nstable;
            hist.push_back(bus.buttons);
            void'(hist.pop_front());
        end
    endtask

    // One clock: apply inputs, update model at the edge, compare 1 ns later.
    task automatic cyc(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e,
                       input logic r);
        bus.buttons   = b;
        bus.repeat_en = e;
        rst           = r;
        @(posedge clk);
        model_edge();
        #1;
        check_eq("pulses", bus.pulses, exp_pulses);
        check_eq("held", bus.held, exp_held);
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.pulses[i] === 1'b1) pulse_cnt[i]++;
            if (bus.held[i] === 1'b1) held_cnt[i]++;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < WIDTH; i++) begin
            pulse_cnt[i] = 0;
            held_cnt[i]  = 0;
        end
    endtask

    initial begin
        int k;
        int rise;
        int fall;
        bit seen;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] bounce;

        for (int i = 0; i < WIDTH; i++) anchor[i] = 0;
        clear_counts();

        // Reset state.
        for (int n = 0; n < 3; n++) cyc('0, '0, 1'b0);
        check_eq("reset_pulses", bus.pulses, 8'h00);
        check_eq("reset_held", bus.held, 8'h00);
        for (int n = 0; n < 6; n++) cyc('0, '0, 1'b1);

        // Clean press on bit 2, no repeat; release.
        clear_counts();
        cyc(8'h04, '0, 1'b1);
        k = edge_n;
        rise = -1;
        for (int n = 0; n < 11; n++) begin
            cyc(8'h04, '0, 1'b1);
            if (rise < 0 && bus.held[2] === 1'b1) rise = edge_n;
        end
        check_eq("press_latency", 8'(rise - k), 8'(DB + 1));
        cyc(8'h00, '0, 1'b1);
        k = edge_n;
        fall = -1;
        for (int n = 0; n < 10; n++) begin
            cyc(8'h00, '0, 1'b1);
            if (fall < 0 && bus.held[2] === 1'b0) fall = edge_n;
        end
        check_eq("release_latency", 8'(fall - k), 8'(DB + 1));
        check_eq("press_pulse_count", 8'(pulse_cnt[2]), 8'd1);

        // Bounce on bit 0: 1,0,1,1,0,1 then low.
        clear_counts();
        bounce = 8'b0010_1101;
        for (int n = 0; n < 6; n++) cyc({7'b0, bounce[n]}, '0, 1'b1);
        for (int n = 0; n < 10; n++) cyc('0, '0, 1'b1);
        check_eq("bounce_pulses", 8'(pulse_cnt[0]), 8'd0);
        check_eq("bounce_held", 8'(held_cnt[0]), 8'd0);

        // Auto-repeat on bit 1 held 30 cycles: 1 press + 7 repeats.
        clear_counts();
        for (int n = 0; n < 30; n++) cyc(8'h02, 8'h02, 1'b1);
        for (int n = 0; n < 12; n++) cyc(8'h00, 8'h02, 1'b1);
        check_eq("repeat_pulse_count", 8'(pulse_cnt[1]), 8'd8);
        check_eq("repeat_released", bus.held, 8'h00);

        // Repeat gating on bit 5: held with enable off, then on.
        for (int n = 0; n < 26; n++) cyc(8'h20, 8'h00, 1'b1);
        for (int n = 0; n < 20; n++) cyc(8'h20, 8'h20, 1'b1);
        cyc(8'h20, 8'h00, 1'b1);
        for (int n = 0; n < 15; n++) cyc(8'h20, 8'h20, 1'b1);
        for (int n = 0; n < 10; n++) cyc(8'h00, 8'h20, 1'b1);

        // Simultaneous channels 8'hA5.
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            cyc(8'hA5, 8'h00, 1'b1);
            if (!seen && bus.held !== 8'h00) begin
                seen = 1'b1;
                check_eq("simul_pulses", bus.pulses, 8'hA5);
                check_eq("simul_held", bus.held, 8'hA5);
            end
        end
        check_eq("simul_seen", {7'b0, seen}, 8'h01);
        for (int n = 0; n < 8; n++) cyc(8'h00, 8'h00, 1'b1);

        // Reset mid-press on bit 3, then a fresh press after release.
        for (int n = 0; n < 8; n++) cyc(8'h08, 8'h00, 1'b1);
        cyc(8'h08, 8'h00, 1'b0);
        cyc(8'h08, 8'h00, 1'b0);
        check_eq("midreset_held", bus.held, 8'h00);
        check_eq("midreset_pulses", bus.pulses, 8'h00);
        clear_counts();
        for (int n = 0; n < 10; n++) cyc(8'h08, 8'h00, 1'b1);
        check_eq("midreset_repress", 8'(pulse_cnt[3]), 8'd1);
        for (int n = 0; n < 8; n++) cyc(8'h00, 8'h00, 1'b1);

        // Random stimulus: sparse toggles give both glitches and long holds.
        b = '0;
        e = '0;
        for (int n = 0; n < 4000; n++) begin
            m = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if ($urandom_range(11, 0) == 0) m[i] = 1'b1;
                if ($urandom_range(39, 0) == 0) e[i] = ~e[i];
            end
            b = b ^ m;
            cyc(b, e, ($urandom_range(499, 0) == 0) ? 1'b0 : 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
